ahb_slave_arbiter: RTL and testbench

Per-slave-port arbiter of the AHB interconnect. It sits directly upstream of the slave-side payload mux. It picks one requesting master per slave port with round-robin priority and holds the grant across fixed-length bursts, undefined-length INCR bursts and locked sequences. It drives the one-hot address-phase select into the request mux and a one-hot data-phase select into the response routing.

---
 rtl/AHB_package.sv | 46 ++++
 rtl/ahb_rr_picker.sv | 26 ++
 rtl/ahb_slave_arbiter.sv | 144 ++++++++++++++
 tb/tb_ahb_slave_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/AHB_package.sv
`default_nettype none
// ============================================================================
// AHB_package -- shared AHB encodings and burst-length decode for the arbiter
// Revision: 1.0
// ============================================================================
package AHB_package;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    BU_SINGLE = 3'd0,
    BU_INCR   = 3'd1,
    BU_WRAP4  = 3'd2,
    BU_INCR4  = 3'd3,
    BU_WRAP8  = 3'd4,
    BU_INCR8  = 3'd5,
    BU_WRAP16 = 3'd6,
    BU_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_BURST = 2'd1,
    ST_INCR  = 2'd2,
    ST_LOCK  = 2'd3
  } arb_state_t;

  localparam int c_cnt_w = 4;

  // SEQ beats still owed after the NONSEQ of a fixed-length burst; 0 otherwise
  function automatic logic [c_cnt_w-1:0] burst_beats_left(input hburst_t b);
    case (b)
      BU_WRAP4,  BU_INCR4:  return 4'd3;
      BU_WRAP8,  BU_INCR8:  return 4'd7;
      BU_WRAP16, BU_INCR16: return 4'd15;
      default:              return 4'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_rr_picker.sv
`default_nettype none
// ============================================================================
// ahb_rr_picker -- one-hot round-robin select, searching upward from i_ptr
// Revision: 1.0
// ============================================================================
module ahb_rr_picker #(
  parameter int CHANNEL_NUM = 2,
  parameter int ID_W        = 1
) (
  input  logic [CHANNEL_NUM-1:0] i_req,
  input  logic [ID_W-1:0]        i_ptr,
  output logic [CHANNEL_NUM-1:0] o_gnt
);

  logic [CHANNEL_NUM-1:0] w_upper_mask;
  logic [CHANNEL_NUM-1:0] w_upper_req;
  logic [CHANNEL_NUM-1:0] w_pool;

  // Requests at or above the pointer win first; otherwise wrap to the lowest
  assign w_upper_mask = ~((CHANNEL_NUM'(1) << i_ptr) - CHANNEL_NUM'(1));
  assign w_upper_req  = i_req & w_upper_mask;
  assign w_pool       = (|w_upper_req) ? w_upper_req : i_req;
  assign o_gnt        = w_pool & (~w_pool + CHANNEL_NUM'(1));

endmodule
`default_nettype wire

// File: rtl/ahb_slave_arbiter.sv
`default_nettype none
// ============================================================================
// ahb_slave_arbiter -- per-slave-port round-robin arbiter with burst/lock hold
// Revision: 1.0
// ============================================================================
module ahb_slave_arbiter
  import AHB_package::*;
#(
  parameter int CHANNEL_NUM = 2,
  parameter int ID_W        = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic [CHANNEL_NUM-1:0]      hreq,
  input  logic [CHANNEL_NUM-1:0][1:0] htrans,
  input  logic [CHANNEL_NUM-1:0][2:0] hburst,
  input  logic [CHANNEL_NUM-1:0]      hmastlock,
  input  logic                        hready,
  output logic [CHANNEL_NUM-1:0]      addr_sel,
  output logic [CHANNEL_NUM-1:0]      data_sel,
  output logic [ID_W-1:0]             hmaster,
  output logic                        hmastlock_out
);

  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  logic [c_cnt_w-1:0]     r_cnt;
  logic [c_cnt_w-1:0]     w_cnt_nxt;
  logic [ID_W-1:0]        r_ptr;
  logic [ID_W-1:0]        r_hmaster;
  logic [CHANNEL_NUM-1:0] r_addr_sel;
  logic [CHANNEL_NUM-1:0] r_data_sel;
  logic                   r_lock_out;

  logic                   w_own_vld;
  logic                   w_own_req;
  logic                   w_own_lock;
  htrans_t                w_own_trans;
  hburst_t                w_own_burst;
  logic [c_cnt_w-1:0]     w_new_len;
  logic                   w_rearb;
  logic [CHANNEL_NUM-1:0] w_gnt;
  logic [ID_W-1:0]        w_gnt_idx;
  logic [ID_W-1:0]        w_ptr_nxt;

  // hmaster holds after the bus goes idle, so ownership comes from addr_sel
  assign w_own_vld   = |r_addr_sel;
  assign w_own_req   = w_own_vld & hreq[r_hmaster];
  assign w_own_lock  = w_own_vld & hmastlock[r_hmaster];
  assign w_own_trans = htrans_t'(htrans[r_hmaster]);
  assign w_own_burst = hburst_t'(hburst[r_hmaster]);
  assign w_new_len   = burst_beats_left(w_own_burst);

  ahb_rr_picker #(
    .CHANNEL_NUM (CHANNEL_NUM),
    .ID_W        (ID_W)
  ) u_picker (
    .i_req (hreq),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      if (w_gnt[i]) w_gnt_idx = ID_W'(i);
    end
  end

  assign w_ptr_nxt = (w_gnt_idx == ID_W'(CHANNEL_NUM - 1)) ? '0 : w_gnt_idx + ID_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rearb     = 1'b0;
    if (hready) begin
      if (w_own_lock) begin
        w_state_nxt = ST_LOCK;
      end else begin
        w_rearb = 1'b1;
        case (r_state)
          ST_BURST: begin
            if (w_own_req && w_own_trans == TR_BUSY) begin
              w_rearb = 1'b0;
            end else if (w_own_req && w_own_trans == TR_SEQ && r_cnt > 4'd1) begin
              w_rearb   = 1'b0;
              w_cnt_nxt = r_cnt - 4'd1;
            end
          end
          ST_INCR: begin
            if (w_own_req && (w_own_trans == TR_SEQ || w_own_trans == TR_BUSY)) w_rearb = 1'b0;
          end
          default: ;
        endcase
        // A fresh NONSEQ from the owner starts (or restarts) a held sequence
        if (r_state != ST_LOCK && w_own_req && w_own_trans == TR_NONSEQ) begin
          if (w_own_burst == BU_INCR) begin
            w_rearb     = 1'b0;
            w_state_nxt = ST_INCR;
          end else if (w_new_len != '0) begin
            w_rearb     = 1'b0;
            w_state_nxt = ST_BURST;
            w_cnt_nxt   = w_new_len;
          end
        end
        if (w_rearb) begin
          w_state_nxt = ST_ARB;
          w_cnt_nxt   = '0;
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= ST_ARB;
      r_cnt      <= '0;
      r_ptr      <= '0;
      r_hmaster  <= '0;
      r_addr_sel <= '0;
      r_data_sel <= '0;
      r_lock_out <= 1'b0;
    end else if (hready) begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_lock_out <= w_own_lock;
      r_data_sel <= (w_own_trans == TR_NONSEQ || w_own_trans == TR_SEQ) ? r_addr_sel : '0;
      if (w_rearb) begin
        r_addr_sel <= w_gnt;
        if (|w_gnt) begin
          r_hmaster <= w_gnt_idx;
          r_ptr     <= w_ptr_nxt;
        end
      end
    end
  end

  assign addr_sel      = r_addr_sel;
  assign data_sel      = r_data_sel;
  assign hmaster       = r_hmaster;
  assign hmastlock_out = r_lock_out;

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ahb_slave_arbiter -- directed and random checks against a behavioural model
// Revision: 1.0
// ============================================================================
module tb_ahb_slave_arbiter;

  localparam int N  = 2;
  localparam int IW = 1;

  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NONSEQ = 2'd2, T_SEQ = 2'd3;
  localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_INCR4 = 3'd3, B_INCR8 = 3'd5, B_INCR16 = 3'd7;
  localparam int MD_ARB = 0, MD_FIXED = 1, MD_UNDEF = 2, MD_LOCKED = 3;

  logic                HCLK = 1'b0;
  logic                HRESETn = 1'b1;
  logic [N-1:0]        hreq;
  logic [N-1:0][1:0]   htrans;
  logic [N-1:0][2:0]   hburst;
  logic [N-1:0]        hmastlock;
  logic                hready;
  logic [N-1:0]        addr_sel;
  logic [N-1:0]        data_sel;
  logic [IW-1:0]       hmaster;
  logic                hmastlock_out;

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model: who owns the port, what kind of sequence it is in, beats left
  bit            m_vld;
  logic [IW-1:0] m_own, m_hmaster, m_ptr;
  int            m_mode, m_left;
  logic [N-1:0]  m_data;
  logic          m_lock;

  always #5 HCLK = ~HCLK;

  ahb_slave_arbiter #(.CHANNEL_NUM(N)) dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .hreq          (hreq),
    .htrans        (htrans),
    .hburst        (hburst),
    .hmastlock     (hmastlock),
    .hready        (hready),
    .addr_sel      (addr_sel),
    .data_sel      (data_sel),
    .hmaster       (hmaster),
    .hmastlock_out (hmastlock_out)
  );

  function automatic int fixed_beats(input logic [2:0] b);
    if (b < 3'd2) return 0;
    return 4 << ((int'(b) - 2) / 2);
  endfunction

  task automatic model_reset();
    m_vld = 1'b0; m_own = '0; m_hmaster = '0; m_ptr = '0;
    m_mode = MD_ARB; m_left = 0; m_data = '0; m_lock = 1'b0;
  endtask

  task automatic model_clock();
    logic [1:0] tr;
    logic [2:0] br;
    bit rq, lk, rearb;
    int c;
    if (!hready) return;
    tr = htrans[m_own];
    br = hburst[m_own];
    rq = m_vld && hreq[m_own];
    lk = m_vld && hmastlock[m_own];
    m_data = '0;
    if (m_vld && (tr == T_NONSEQ || tr == T_SEQ)) m_data[m_own] = 1'b1;
    m_lock = lk;
    if (lk) begin
      m_mode = MD_LOCKED;
      return;
    end
    rearb = 1'b1;
    if (m_mode != MD_LOCKED && rq) begin
      if (tr == T_NONSEQ) begin
        if (br == B_INCR) begin
          m_mode = MD_UNDEF; rearb = 1'b0;
        end else if (fixed_beats(br) > 0) begin
          m_mode = MD_FIXED; m_left = fixed_beats(br) - 1; rearb = 1'b0;
        end
      end else if (m_mode == MD_FIXED && tr == T_SEQ) begin
        m_left--;
        rearb = (m_left == 0);
      end else if ((m_mode == MD_FIXED || m_mode == MD_UNDEF) && tr == T_BUSY) begin
        rearb = 1'b0;
      end else if (m_mode == MD_UNDEF && tr == T_SEQ) begin
        rearb = 1'b0;
      end
    end
    if (rearb) begin
      m_mode = MD_ARB;
      m_vld  = 1'b0;
      for (int k = 0; k < N; k++) begin
        c = (int'(m_ptr) + k) % N;
        if (!m_vld && hreq[c]) begin
          m_vld = 1'b1; m_own = IW'(c); m_hmaster = IW'(c); m_ptr = IW'((c + 1) % N);
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] ea;
    ea = '0;
    if (m_vld) ea[m_own] = 1'b1;
    chk({tag, ".addr_sel"}, 32'(addr_sel), 32'(ea));
    chk({tag, ".data_sel"}, 32'(data_sel), 32'(m_data));
    chk({tag, ".hmaster"}, 32'(hmaster), 32'(m_hmaster));
    chk({tag, ".hmastlock_out"}, 32'(hmastlock_out), 32'(m_lock));
  endtask

  task automatic step(input string tag);
    @(posedge HCLK);
    model_clock();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input int ch, input bit rq, input logic [1:0] tr, input logic [2:0] br, input bit lk);
    hreq[ch] = rq; htrans[ch] = tr; hburst[ch] = br; hmastlock[ch] = lk;
  endtask

  initial begin
    hreq = '0; htrans = '0; hburst = '0; hmastlock = '0; hready = 1'b1;
    model_reset();
    #2 HRESETn = 1'b0;
    #10;
    check_all("reset");
    chk("reset_addr_sel", 32'(addr_sel), 32'h0);
    @(negedge HCLK) HRESETn = 1'b1;

    // Basic grant: both masters issue SINGLE NONSEQ continuously
    drive(0, 1, T_NONSEQ, B_SINGLE, 0);
    drive(1, 1, T_NONSEQ, B_SINGLE, 0);
    step("basic");
    chk("basic_g0", 32'(addr_sel), 32'h1);
    step("basic");
    chk("basic_g1", 32'(addr_sel), 32'h2);
    chk("basic_d1", 32'(data_sel), 32'h1);
    step("basic");
    chk("basic_g2", 32'(addr_sel), 32'h1);
    chk("basic_d2", 32'(data_sel), 32'h2);
    step("basic");

    drive(0, 0, T_IDLE, B_SINGLE, 0);
    drive(1, 0, T_IDLE, B_SINGLE, 0);
    step("idle");
    chk("idle_addr_sel", 32'(addr_sel), 32'h0);

    // INCR4 with one BUSY; ch1 requests throughout
    drive(0, 1, T_IDLE, B_SINGLE, 0);
    drive(1, 1, T_IDLE, B_SINGLE, 0);
    step("incr4_grant");
    chk("incr4_grant", 32'(addr_sel), 32'h1);
    drive(0, 1, T_NONSEQ, B_INCR4, 0); step("incr4"); chk("incr4_nonseq", 32'(addr_sel), 32'h1);
    drive(0, 1, T_SEQ,    B_INCR4, 0); step("incr4"); chk("incr4_seq1",   32'(addr_sel), 32'h1);
    drive(0, 1, T_BUSY,   B_INCR4, 0); step("incr4"); chk("incr4_busy",   32'(addr_sel), 32'h1);
    drive(0, 1, T_SEQ,    B_INCR4, 0); step("incr4"); chk("incr4_seq2",   32'(addr_sel), 32'h1);
    drive(0, 1, T_SEQ,    B_INCR4, 0); step("incr4"); chk("incr4_end",    32'(addr_sel), 32'h2);

    // Wait states right after the NONSEQ of an INCR4
    drive(1, 1, T_IDLE, B_SINGLE, 0);
    drive(0, 1, T_IDLE, B_SINGLE, 0);
    step("wait_grant");
    drive(0, 1, T_NONSEQ, B_INCR4, 0); step("wait");
    drive(0, 1, T_SEQ, B_INCR4, 0);
    hready = 1'b0;
    repeat (3) step("wait_hold");
    chk("wait_addr_frozen", 32'(addr_sel), 32'h1);
    chk("wait_data_frozen", 32'(data_sel), 32'h1);
    hready = 1'b1;
    step("wait_resume"); step("wait_resume");
    chk("wait_before_end", 32'(addr_sel), 32'h1);
    step("wait_resume");
    chk("wait_end", 32'(addr_sel), 32'h2);

    // Locked pair of INCR4 bursts from ch1 while ch0 requests
    drive(0, 1, T_IDLE, B_SINGLE, 0);
    drive(1, 1, T_NONSEQ, B_INCR4, 1);
    step("lock");
    for (int i = 0; i < 7; i++) begin
      drive(1, 1, (i == 3) ? T_NONSEQ : T_SEQ, B_INCR4, 1);
      step("lock");
      chk("lock_addr_held", 32'(addr_sel), 32'h2);
      chk("lock_out_high", 32'(hmastlock_out), 32'h1);
    end
    drive(1, 1, T_IDLE, B_SINGLE, 0);
    step("lock_release");
    chk("lock_release", 32'(addr_sel), 32'h1);

    // Early termination of INCR8 after two SEQ beats
    drive(1, 1, T_IDLE, B_SINGLE, 0);
    drive(0, 1, T_NONSEQ, B_INCR8, 0); step("early");
    drive(0, 1, T_SEQ, B_INCR8, 0); step("early"); step("early");
    chk("early_held", 32'(addr_sel), 32'h1);
    drive(0, 0, T_IDLE, B_SINGLE, 0); step("early_drop");
    chk("early_switch", 32'(addr_sel), 32'h2);

    // Reset in the middle of an INCR16 from ch0 (pointer then favours ch1)
    drive(1, 0, T_IDLE, B_SINGLE, 0);
    drive(0, 1, T_IDLE, B_SINGLE, 0);
    step("rst_grant");
    drive(1, 1, T_IDLE, B_SINGLE, 0);
    drive(0, 1, T_NONSEQ, B_INCR16, 0); step("rst_burst");
    drive(0, 1, T_SEQ, B_INCR16, 0); step("rst_burst"); step("rst_burst");
    HRESETn = 1'b0;
    model_reset();
    #1;
    check_all("mid_reset");
    chk("mid_reset_addr", 32'(addr_sel), 32'h0);
    @(negedge HCLK) HRESETn = 1'b1;
    drive(0, 1, T_IDLE, B_SINGLE, 0);
    drive(1, 1, T_IDLE, B_SINGLE, 0);
    step("post_reset");
    chk("post_reset_first", 32'(addr_sel), 32'h1);

    // Random traffic including wait states, locks and occasional resets
    for (int n = 0; n < 800; n++) begin
      for (int c = 0; c < N; c++) begin
        drive(c, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
              3'($urandom_range(0, 7)), $urandom_range(0, 9) == 0);
      end
      hready = $urandom_range(0, 3) != 0;
      step("rand");
      if ($urandom_range(0, 199) == 0) begin
        HRESETn = 1'b0;
        model_reset();
        #1;
        check_all("rand_reset");
        #2 HRESETn = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
